// File: rtl/sbuf_mc.sv
// Multi-channel sample capture buffer with registered bus readback.
// Optional saturation-flag capture is built when SBUF_MC_SAT_EN is defined.

module sbuf_lane #(
  parameter int DW  = 16,
  parameter int AW  = 8,
  parameter int SAW = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  acc,
  input  logic [AW-1:0]         wadr,
  input  logic [DW-1:0]         samp,
`ifdef SBUF_MC_SAT_EN
  input  logic                  sat_bit,
  input  logic [$clog2(DW)-1:0] sat_cnt,
  input  logic [SAW-1:0]        sat_wadr,
  input  logic                  fin_wr,
  output logic [DW-1:0]         rd_sat,
`endif
  input  logic [AW-1:0]         radr,
  output logic [DW-1:0]         rd_smp
);
  logic [DW-1:0] smp_mem [2**AW];

  always_ff @(posedge clk)
    if (acc) smp_mem[wadr] <= samp;

  // Asynchronous array read; the top registers it, so same-cycle writes read old data.
  assign rd_smp = smp_mem[radr];

`ifdef SBUF_MC_SAT_EN
  logic [DW-1:0] agg, word_nxt;
  logic [DW-1:0] sat_mem [2**SAW];

  always_comb begin
    word_nxt          = agg;
    word_nxt[sat_cnt] = sat_bit;
  end

  always_ff @(posedge clk) begin
    if (rst || start)  agg <= '0;
    else if (acc)      agg <= (&sat_cnt) ? '0 : word_nxt;
    else if (fin_wr)   agg <= '0;
  end

  // Full words land on the DW-th bit; a partial word is flushed on finish.
  always_ff @(posedge clk) begin
    if (acc && (&sat_cnt)) sat_mem[sat_wadr] <= word_nxt;
    else if (fin_wr)       sat_mem[sat_wadr] <= agg;
  end

  assign rd_sat = sat_mem[radr[SAW-1:0]];
`endif
endmodule

module sbuf_mc #(
  parameter int CH = 4,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(CH)+AW:0]      sbus_radr,
  output logic [DW-1:0]               sbus_rdata,
  input  logic [AW:0]                 run_cntr,
  input  logic                        start,
  output logic                        s_running,
  output logic                        finish,
  input  logic [CH*DW-1:0]            s_out,
  input  logic [CH-1:0]               sat,
  input  logic                        sw,
  output logic                        overrun
);
  localparam int CW  = $clog2(CH);
  localparam int LW  = $clog2(DW);
  localparam int SAW = AW - LW;

  logic [AW:0]                run_cnt;
  logic [AW-1:0]              wadr;
  logic                       acc;
  logic [CH-1:0][DW-1:0]      lane_in;
  logic [CH-1:0][DW-1:0]      rd_smp;
  logic                       sel_sat;
  logic [CW-1:0]              rd_ch;

  assign lane_in   = s_out;
  assign s_running = |run_cnt;
  assign acc       = sw & s_running & ~start & ~rst;
  assign sel_sat   = sbus_radr[AW+CW];
  assign rd_ch     = sbus_radr[AW+CW-1:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      wadr    <= '0;
      finish  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      finish <= acc && (run_cnt == (AW+1)'(1));
      if (start) begin
        // Clamp so a run never wraps the sample buffer.
        run_cnt <= run_cntr[AW] ? {1'b1, {AW{1'b0}}} : run_cntr;
        wadr    <= '0;
        overrun <= 1'b0;
      end else begin
        if (acc) begin
          run_cnt <= run_cnt - 1'b1;
          wadr    <= wadr + 1'b1;
        end
        if (sw && !s_running) overrun <= 1'b1;
      end
    end
  end

`ifdef SBUF_MC_SAT_EN
  logic [LW-1:0]         sat_cnt;
  logic [SAW-1:0]        sat_wadr;
  logic                  fin_wr;
  logic [CH-1:0][DW-1:0] rd_sat;

  assign fin_wr = finish & (|sat_cnt) & ~rst;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      sat_cnt  <= '0;
      sat_wadr <= '0;
    end else if (acc) begin
      sat_cnt <= sat_cnt + 1'b1;
      if (&sat_cnt) sat_wadr <= sat_wadr + 1'b1;
    end else if (fin_wr) begin
      sat_cnt  <= '0;
      sat_wadr <= sat_wadr + 1'b1;
    end
  end

  sbuf_lane #(.DW(DW), .AW(AW), .SAW(SAW)) u_lane [CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .acc      (acc),
    .wadr     (wadr),
    .samp     (lane_in),
    .sat_bit  (sat),
    .sat_cnt  (sat_cnt),
    .sat_wadr (sat_wadr),
    .fin_wr   (fin_wr),
    .rd_sat   (rd_sat),
    .radr     (sbus_radr[AW-1:0]),
    .rd_smp   (rd_smp)
  );

  always_ff @(posedge clk) begin
    if (rst) sbus_rdata <= '0;
    else     sbus_rdata <= sel_sat ? rd_sat[rd_ch] : rd_smp[rd_ch];
  end
`else
  logic unused_sat;
  assign unused_sat = ^sat;

  sbuf_lane #(.DW(DW), .AW(AW), .SAW(SAW)) u_lane [CH-1:0] (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .acc      (acc),
    .wadr     (wadr),
    .samp     (lane_in),
    .radr     (sbus_radr[AW-1:0]),
    .rd_smp   (rd_smp)
  );

  always_ff @(posedge clk) begin
    if (rst) sbus_rdata <= '0;
    else     sbus_rdata <= sel_sat ? '0 : rd_smp[rd_ch];
  end
`endif
endmodule

// File: tb/tb_sbuf_mc.sv
// Directed scoreboard bench for sbuf_mc: reads are queued with expected data
// and checked by a monitor one cycle later; control outputs are checked inline.

module tb_sbuf_mc;
  localparam int CH = 4, DW = 16, AW = 8;
  localparam int RW = 1 + 2 + AW;

`ifdef SBUF_MC_SAT_EN
  localparam logic [DW-1:0] SAT_A = 16'h0008, SAT_B = 16'h0002, SAT_R = 16'h0002;
`else
  localparam logic [DW-1:0] SAT_A = 16'h0000, SAT_B = 16'h0000, SAT_R = 16'h0000;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [RW-1:0]    sbus_radr;
  logic [DW-1:0]    sbus_rdata;
  logic [AW:0]      run_cntr;
  logic             start, s_running, finish, sw, overrun;
  logic [CH*DW-1:0] s_out;
  logic [CH-1:0]    sat;

  int errors = 0, checks = 0, fin_cnt = 0;
  logic rd_req = 1'b0, rd_vld = 1'b0;

  typedef struct { string name; logic [DW-1:0] exp; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sbuf_mc #(.CH(CH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .sbus_radr(sbus_radr), .sbus_rdata(sbus_rdata),
    .run_cntr(run_cntr), .start(start), .s_running(s_running), .finish(finish),
    .s_out(s_out), .sat(sat), .sw(sw), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: read data is valid the cycle after the address was presented.
  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    exp_t e;
    if (finish) fin_cnt++;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_unexpected: got %0h with empty scoreboard", sbus_rdata);
      end else begin
        e = exp_q.pop_front();
        chk(e.name, 32'(sbus_rdata), 32'(e.exp));
      end
    end
  end

  // One stimulus cycle: lane i = base + mul*i + n.
  task automatic cyc(input logic st, input logic w, input int rc, input int base,
                     input int mul, input int n, input logic [CH-1:0] s);
    @(negedge clk);
    start = st; sw = w; run_cntr = (AW+1)'(rc); sat = s; rd_req = 1'b0;
    for (int i = 0; i < CH; i++) s_out[i*DW +: DW] = DW'(base + mul*i + n);
  endtask

  task automatic rd(input string name, input logic sel, input int ch, input int w,
                    input logic [DW-1:0] exp);
    exp_t e;
    @(negedge clk);
    start = 1'b0; sw = 1'b0; rd_req = 1'b1;
    sbus_radr = {sel, 2'(ch), 8'(w)};
    e.name = name; e.exp = exp;
    exp_q.push_back(e);
  endtask

  task automatic rd_done();
    @(negedge clk);
    rd_req = 1'b0;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_drain: %0d reads pending, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; sw = 1'b0; run_cntr = '0; s_out = '0; sat = '0; sbus_radr = '0;
    repeat (3) @(negedge clk);
    chk("rst_running", s_running, 0);
    chk("rst_finish", finish, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rdata", sbus_rdata, 0);
    rst = 1'b0;

    // Clamp: 300 requested, 256 captured
    cyc(1, 0, 300, 0, 'h1000, 0, 0);
    for (int n = 0; n < 256; n++) begin
      cyc(0, 1, 0, 0, 'h1000, n, 0);
      if (n == 0)   chk("clamp_running_first", s_running, 1);
      if (n == 255) chk("clamp_running_last", s_running, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("clamp_running_end", s_running, 0);
    chk("clamp_finish", finish, 1);
    rd("clamp_ch3_w0", 0, 3, 0, 16'h3000);
    rd("clamp_ch2_w255", 0, 2, 255, 16'h20FF);
    rd_done();
    chk("fin_cnt_clamp", fin_cnt, 1);

    // Overrun: idle sw writes nothing (write address sits at 0)
    cyc(0, 1, 0, 'hFFFF, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("ovr_set", overrun, 1);
    rd("ovr_ch3_w0", 0, 3, 0, 16'h3000);
    rd("ovr_ch0_w1", 0, 0, 1, 16'h0001);
    rd_done();
    chk("ovr_sticky", overrun, 1);

    // 20-sample run with saturation flags on lane 1
    cyc(1, 0, 20, 0, 0, 0, 0);
    for (int n = 0; n < 20; n++) begin
      cyc(0, 1, 0, 0, 'h100, n, (n == 3 || n == 17) ? 4'b0010 : 4'b0000);
      if (n == 0) chk("ovr_clr", overrun, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("run20_finish", finish, 1);
    chk("run20_running", s_running, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("run20_finish_once", finish, 0);
    for (int n = 0; n < 20; n++) rd("run20_ch1", 0, 1, n, DW'(16'h100 + n));
    rd("run20_ch3_w5", 0, 3, 5, 16'h0305);
    rd("run20_sat0", 1, 1, 0, SAT_A);
    rd("run20_sat1", 1, 1, 1, SAT_B);
    rd_done();
    chk("fin_cnt_run20", fin_cnt, 2);

    // Restart after 5 samples with run_cntr=3
    cyc(1, 0, 10, 0, 0, 0, 0);
    for (int n = 0; n < 5; n++) cyc(0, 1, 0, 'hE000, 'h100, n, (n == 2) ? 4'b0001 : 4'b0000);
    cyc(1, 0, 3, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 'hD000, 'h100, k, (k == 1) ? 4'b0001 : 4'b0000);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("restart_finish", finish, 1);
    for (int k = 0; k < 3; k++) rd("restart_ch0", 0, 0, k, DW'(16'hD000 + k));
    rd("restart_ch0_w3", 0, 0, 3, 16'hE003);
    rd("restart_ch2_w4", 0, 2, 4, 16'hE204);
    rd("restart_ch1_w5", 0, 1, 5, 16'h0105);
    rd("restart_sat", 1, 0, 0, SAT_R);
    rd_done();
    chk("fin_cnt_restart", fin_cnt, 3);

    // start with sw: that sample is dropped, counter = 7
    cyc(1, 1, 7, 'hBEEF, 0, 0, 0);
    for (int n = 0; n < 7; n++) begin
      cyc(0, 1, 0, 'h7000, 'h100, n, 0);
      if (n == 6) chk("stsw_running_last", s_running, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("stsw_running_end", s_running, 0);
    chk("stsw_finish", finish, 1);
    rd("stsw_ch0_w0", 0, 0, 0, 16'h7000);
    rd("stsw_ch1_w6", 0, 1, 6, 16'h7106);
    rd("stsw_ch0_w7", 0, 0, 7, 16'h0007);
    rd_done();

    // rst mid-run, with sw in the reset cycle
    cyc(1, 0, 10, 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) cyc(0, 1, 0, 'h5000, 'h100, n, 0);
    @(negedge clk);
    rst = 1'b1; sw = 1'b1; start = 1'b0;
    @(negedge clk);
    rst = 1'b0; sw = 1'b0;
    chk("rstmid_running", s_running, 0);
    chk("rstmid_finish", finish, 0);
    chk("rstmid_overrun", overrun, 0);
    chk("rstmid_rdata", sbus_rdata, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rstmid_still_idle", s_running, 0);
    chk("fin_cnt_final", fin_cnt, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sbuf_mc.md
SBUF_MC -- requirements
Module: sbuf_mc

Interface
REQ-001 SHALL have parameters: CH, default 4, number of output channels; DW, default 16, sample and read word width; AW, default 8, log2 of sample buffer depth per channel.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- sbus_radr  in  1+log2(CH)+AW  read address: {sel_sat, channel, word}.
- sbus_rdata  out  DW  read data.
- run_cntr  in  AW+1  number of samples to capture, loaded on start.
- start  in  1  begin a capture run.
- s_running  out  1  capture run active.
- finish  out  1  one-cycle end-of-run pulse.
- s_out  in  CH*DW  sample lanes; lane i is s_out[i*DW +: DW].
- sat  in  CH  per-lane saturation flag.
- sw  in  1  sample write strobe.
- overrun  out  1  sticky flag: sw arrived while idle.

Function
REQ-003 On start, SHALL load the run counter with min(run_cntr, 2^AW) and zero the write address, saturation bit counter, saturation aggregators, saturation write address and overrun.
REQ-004 start SHALL take priority over sw in the same cycle; that sw is neither written nor counted.
REQ-005 s_running SHALL equal (run counter != 0), combinationally from the registered counter.
REQ-006 An accepted sample is sw & s_running & ~start. Each accepted sample SHALL:
- write lane i into channel i buffer at the write address, for all lanes in one cycle;
- increment the write address by 1;
- decrement the run counter by 1.
REQ-007 sw while not running and not in a start cycle SHALL set overrun (stays set until start or rst) and SHALL write nothing.
REQ-008 finish SHALL pulse high for exactly one cycle, in the cycle after the last accepted sample, only when s_running falls because the counter reaches 0.
REQ-009 finish SHALL NOT pulse when s_running falls because of start (start with run_cntr=0 mid-run) or because of rst; start with run_cntr=0 while idle SHALL produce no run and no finish.
REQ-010 start during a run SHALL restart the capture: pointers reset per REQ-003, the partial saturation word is discarded, and earlier RAM contents remain readable until overwritten.
REQ-011 Saturation capture, per channel i:
- the sat[i] of accepted sample n goes to bit (n mod DW) of the aggregator, LSB first;
- when the DW-th bit is captured, the word (including that bit) SHALL be written to the channel-i saturation buffer at the saturation write address, and the address SHALL increment.
REQ-012 When finish pulses with a nonzero partial bit count, the partial word SHALL be written in that cycle with its unfilled upper bits zero. With a zero partial count, no extra write SHALL occur.
REQ-013 Saturation buffer depth per channel SHALL be 2^AW/DW words; its address uses the low AW-log2(DW) bits of the word field, and upper word bits are ignored.
REQ-014 Reads:
- sel_sat=0 selects the sample buffer, sel_sat=1 the saturation buffer, for the addressed channel;
- sbus_rdata SHALL be registered, valid one cycle after sbus_radr;
- a read and write to the same location in the same cycle SHALL return the old data.
REQ-015 Write address arithmetic SHALL be modulo the buffer depth. With run counter clamping (REQ-003) no wrap occurs within a run.

Reset
REQ-016 rst SHALL clear: run counter, write address, saturation counter, aggregators, saturation write address, overrun, finish history and the sbus_rdata register; all outputs read 0 the cycle after rst.
REQ-017 rst SHALL override start and sw in the same cycle; RAM contents need not be cleared.

Configuration
REQ-018 Macro SBUF_MC_SAT_EN:
- defined: saturation aggregators and buffers are built per REQ-011 to REQ-013;
- undefined: they are omitted, the sat input is ignored, and reads with sel_sat=1 return 0.

Verification
REQ-019 The bench SHALL cover these directed scenarios (CH=4, DW=16, AW=8):
- run_cntr=20, 20 sw with lane i = 0x100*i + n, sat[1] high on n=3 and n=17 -> channel 1 samples 0..19 read back correctly; sat words 0x0008 at sat addr 0 and 0x0002 at sat addr 1; finish pulses once, the cycle after the 20th sw.
- sw asserted while idle -> overrun=1, no RAM change; next start -> overrun=0.
- start with run_cntr=300 -> clamps to 256 samples; s_running drops after 256 sw.
- start asserted at sample 5 of a run with run_cntr=3 -> address restarts at 0, 3 more samples captured, exactly one finish.
- start together with sw -> sample not written, counter equals run_cntr.
- rst mid-run -> s_running=0, no finish; with SBUF_MC_SAT_EN undefined, sel_sat reads return 0.
